alu_shift_seq: RTL and testbench
================================

Name: alu_shift_seq

Overview:
- Multi-cycle, multi-lane shift engine: SETS independent WIDTH-bit lanes, each with its own shift amount, processed iteratively STEP bit positions per clock.
- Successor to the combinational shift path. Adds an explicit mode field (logical left, logical right, arithmetic right, rotate), saturating amounts, and a valid/ready handshake on both sides.
- Sits between the ALU operand stage and the result writeback stage.

Parameters:
- WIDTH, 8: bits per lane; must be at least 2.
- SETS, 2: number of lanes; must be at least 1.
- STEP, 1: maximum bit positions shifted per cycle per lane; range 1..WIDTH.
- AMT_W, $clog2(WIDTH)+1: width of each lane's shift-amount field (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  block can accept a bundle
- in_packed  in  SETS*WIDTH  lane i data at [i*WIDTH +: WIDTH]
- amt_packed  in  SETS*AMT_W  lane i amount at [i*AMT_W +: AMT_W]
- mode  in  2  0 = LSL, 1 = LSR, 2 = ASR, 3 = ROR; shared by all lanes
- out_valid  out  1  result bundle valid
- out_ready  in  1  downstream accepts the result
- out_packed  out  SETS*WIDTH  shifted data per lane
- overflow_packed  out  SETS*WIDTH  shifted-out bits per lane
- busy  out  1  high in SHIFT state

Behaviour:
- Reset: asynchronous, active-low. Drives state to IDLE; out_valid=0, in_ready=1 (deasserted during reset), busy=0, and out_packed, overflow_packed and all internal registers to 0. Reset mid-operation discards the bundle in flight.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch data, mode and amounts.
  - Each amount saturates to WIDTH, except ROR, where amount is taken modulo WIDTH.
  - Next state is SHIFT; go directly to DONE if every lane's effective amount is 0.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle, every lane with remaining r>0 shifts by k=min(STEP,r) and decrements r by k.
  - When all lanes reach r=0, move to DONE.
- DONE:
  - out_valid=1; outputs are stable.
  - On out_ready, go to IDLE. A new input is not accepted in the same cycle (in_ready only in IDLE).
  - out_valid holds indefinitely under backpressure.
- Latency, accept edge to out_valid: ceil(max effective amount / STEP) + 1 cycles; an all-zero amount bundle gives 1 cycle.
- Fill rules:
  - LSL and LSR fill with 0.
  - ASR fills with the lane's original MSB.
  - ROR fills with the bits leaving the LSB.
- Overflow rules:
  - LSL: overflow = in >> (WIDTH - amt), right-aligned.
  - LSR and ASR: overflow = in & ((1<<amt) - 1), in original bit positions.
  - ROR: overflow = 0.
  - Amount 0: overflow = 0.
- Saturation: LSL or LSR by WIDTH gives out=0 and overflow=in. ASR by WIDTH gives out = all sign bits and overflow=in.
- Final out and overflow equal the single-cycle result for the same operands, independent of STEP.

Optional Feature:
- ALU_SHIFT_ROTATE_EN defined: mode 3 performs ROR as above.
- Not defined: mode 3 is accepted but treated as amount 0 on all lanes. Result is out=in, overflow=0, with 1-cycle latency. Rotate logic is not synthesised.

Decomposition:
- Package alu_shift_pkg holds:
  - the mode encoding constants (MODE_LSL, MODE_LSR, MODE_ASR, MODE_ROR);
  - the FSM state encoding (ST_IDLE, ST_SHIFT, ST_DONE);
  - the AMT_W derivation function.
- One sub-module, alu_shift_lane: per-lane data, remaining-count and overflow registers with one k-bit step. It is instantiated SETS times in a generate loop. The top level keeps the FSM and handshake.

Test Plan:
(Parameters: WIDTH=8, SETS=2, STEP=1 unless stated.)
- LSL: lane0 0x96 amt 3, lane1 0x01 amt 7 -> lane0 out 0xB0, ovf 0x04; lane1 out 0x80, ovf 0x00; out_valid 8 cycles after accept.
- ASR: lane0 0x96 amt 2 -> out 0xE5, ovf 0x02. LSR: lane1 0x96 amt 4 -> out 0x09, ovf 0x06.
- Saturation: LSL 0xA5 amt 9 -> out 0x00, ovf 0xA5. ASR 0x80 amt 8 -> out 0xFF, ovf 0x80. Amount 0 on both lanes -> out=in, out_valid 1 cycle after accept.
- ROR 0x96 amt 4 -> 0x69 with macro defined; 0x96 unchanged with macro undefined. Repeat with STEP=3 and amt 7: identical result, latency 4.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and data stable, in_ready=0; first out_ready cycle returns to IDLE.
- Reset: assert rst_n=0 in the 3rd SHIFT cycle -> outputs 0, state IDLE immediately. After release, a fresh bundle completes correctly.

Source files
------------

// File: rtl/alu_shift_pkg.sv
// Shared definitions for the multi-lane sequential shift engine.
// Rotate support is enabled by defining ALU_SHIFT_ROTATE_EN.
package alu_shift_pkg;

  localparam logic [1:0] MODE_LSL = 2'd0;
  localparam logic [1:0] MODE_LSR = 2'd1;
  localparam logic [1:0] MODE_ASR = 2'd2;
  localparam logic [1:0] MODE_ROR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Amount field must hold the value WIDTH itself (saturated shift).
  function automatic int unsigned amt_width(input int unsigned width);
    return int'($clog2(width)) + 1;
  endfunction

endpackage

// File: rtl/alu_shift_lane.sv
// One shift lane: data, remaining-count and overflow registers, advancing up to STEP bits per cycle.
// Rotate datapath only present when ALU_SHIFT_ROTATE_EN is defined.
module alu_shift_lane
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = amt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] ovf,
  output logic             zero_c,
  output logic             last_c
);

  localparam logic [AMT_W-1:0] W_AMT    = AMT_W'(WIDTH);
  localparam logic [AMT_W-1:0] STEP_AMT = AMT_W'(STEP);

  logic [WIDTH-1:0] data_q, ovf_q, data_n_c, ovf_n_c, mask_c, low_c;
  logic [AMT_W-1:0] rem_q, tot_q, amt_eff_c, k_c, pos_c;
  logic [1:0]       mode_q;

  // Effective amount: saturate to WIDTH, or wrap for rotate.
  always_comb begin
    amt_eff_c = amt;
    if (mode == MODE_ROR) begin
`ifdef ALU_SHIFT_ROTATE_EN
      amt_eff_c = amt % W_AMT;
`else
      amt_eff_c = '0;
`endif
    end else if (amt > W_AMT) begin
      amt_eff_c = W_AMT;
    end
  end

  assign zero_c = (amt_eff_c == '0);
  assign last_c = (rem_q <= STEP_AMT);

  // One k-bit step; pos_c is how far the data has already moved, so right-shift
  // overflow lands back in its original bit positions.
  always_comb begin
    k_c      = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    pos_c    = tot_q - rem_q;
    mask_c   = ~({WIDTH{1'b1}} << k_c);
    low_c    = (data_q & mask_c) << pos_c;
    data_n_c = data_q;
    ovf_n_c  = ovf_q;
    case (mode_q)
      MODE_LSL: begin
        data_n_c = data_q << k_c;
        ovf_n_c  = (ovf_q << k_c) | (data_q >> (W_AMT - k_c));
      end
      MODE_LSR: begin
        data_n_c = data_q >> k_c;
        ovf_n_c  = ovf_q | low_c;
      end
      MODE_ASR: begin
        data_n_c = WIDTH'($signed(data_q) >>> k_c);
        ovf_n_c  = ovf_q | low_c;
      end
`ifdef ALU_SHIFT_ROTATE_EN
      MODE_ROR: begin
        data_n_c = (data_q >> k_c) | (data_q << (W_AMT - k_c));
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ovf_q  <= '0;
      rem_q  <= '0;
      tot_q  <= '0;
      mode_q <= MODE_LSL;
    end else if (load) begin
      data_q <= din;
      ovf_q  <= '0;
      rem_q  <= amt_eff_c;
      tot_q  <= amt_eff_c;
      mode_q <= mode;
    end else if (step && (rem_q != '0)) begin
      data_q <= data_n_c;
      ovf_q  <= ovf_n_c;
      rem_q  <= rem_q - k_c;
    end
  end

  assign dout = data_q;
  assign ovf  = ovf_q;

endmodule

// File: rtl/alu_shift_seq.sv
// Multi-lane iterative shift engine with valid/ready on both sides; FSM and handshake live here.
// Optional rotate mode via ALU_SHIFT_ROTATE_EN (mode 3 is a pass-through otherwise).
module alu_shift_seq
  import alu_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SETS  = 2,
  parameter int unsigned STEP  = 1,
  parameter int unsigned AMT_W = amt_width(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SETS*WIDTH-1:0] in_packed,
  input  logic [SETS*AMT_W-1:0] amt_packed,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SETS*WIDTH-1:0] out_packed,
  output logic [SETS*WIDTH-1:0] overflow_packed,
  output logic                  busy
);

  state_t          state_q, state_d;
  logic            out_valid_d, in_ready_d, busy_d;
  logic            accept_c, shift_c;
  logic [SETS-1:0] zero_c, last_c;

  assign accept_c = in_valid && in_ready;
  assign shift_c  = (state_q == ST_SHIFT);

  for (genvar g = 0; g < SETS; g++) begin : g_lane
    alu_shift_lane #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .AMT_W (AMT_W)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept_c),
      .step   (shift_c),
      .din    (in_packed[g*WIDTH +: WIDTH]),
      .amt    (amt_packed[g*AMT_W +: AMT_W]),
      .mode   (mode),
      .dout   (out_packed[g*WIDTH +: WIDTH]),
      .ovf    (overflow_packed[g*WIDTH +: WIDTH]),
      .zero_c (zero_c[g]),
      .last_c (last_c[g])
    );
  end

  // SHIFT leaves on the cycle the final step is taken; out_valid rises one cycle
  // after DONE is entered, so latency is ceil(max/STEP)+1 including the zero case.
  always_comb begin
    state_d     = state_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (accept_c) state_d = (&zero_c) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (&last_c) state_d = ST_DONE;
      ST_DONE: begin
        if (out_valid && out_ready) state_d = ST_IDLE;
        else                        out_valid_d = 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
    busy_d     = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Self-checking bench: STEP=1 and STEP=3 instances driven in lockstep against a behavioural model.
module tb_alu_shift_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_packed = '0;
  logic [7:0]  amt_packed = '0;
  logic [1:0]  mode = 2'd0;

  logic        rdy1, ov1, busy1, rdy3, ov3, busy3;
  logic [15:0] out1, ovf1, out3, ovf3;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_shift_seq #(.WIDTH(8), .SETS(2), .STEP(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_packed(in_packed), .amt_packed(amt_packed), .mode(mode),
    .out_valid(ov1), .out_ready(out_ready), .out_packed(out1),
    .overflow_packed(ovf1), .busy(busy1)
  );

  alu_shift_seq #(.WIDTH(8), .SETS(2), .STEP(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
    .in_packed(in_packed), .amt_packed(amt_packed), .mode(mode),
    .out_valid(ov3), .out_ready(out_ready), .out_packed(out3),
    .overflow_packed(ovf3), .busy(busy3)
  );

  // Single-cycle reference result for one 8-bit lane.
  function automatic void model(input logic [7:0] d, input logic [3:0] a, input logic [1:0] m,
                                output logic [7:0] o, output logic [7:0] v, output int eff);
    int n;
    int sd;
    logic [15:0] w;
    n   = (int'(a) > 8) ? 8 : int'(a);
    eff = n;
    o   = d;
    v   = 8'h00;
    case (m)
      2'd0: begin
        w = 16'(d) << n;
        o = w[7:0];
        v = w[15:8];
      end
      2'd1: begin
        o = 8'(d >> n);
        v = d & 8'((16'd1 << n) - 16'd1);
      end
      2'd2: begin
        sd = d[7] ? int'(d) - 256 : int'(d);
        o  = 8'(sd >>> n);
        v  = d & 8'((16'd1 << n) - 16'd1);
      end
      default: begin
`ifdef ALU_SHIFT_ROTATE_EN
        eff = int'(a) % 8;
        w   = {d, d} >> eff;
        o   = w[7:0];
`else
        eff = 0;
        o   = d;
`endif
      end
    endcase
  endfunction

  function automatic int exp_lat(input int maxeff, input int step);
    return (maxeff == 0) ? 1 : (maxeff + step - 1) / step + 1;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!(rdy1 && rdy3) && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!(rdy1 && rdy3)) begin
      fails++;
      $display("FAIL wait_ready: in_ready got %b/%b, required 1/1", rdy1, rdy3);
    end
  endtask

  // Issue one bundle to both instances, check latency and results, then drain.
  task automatic run_txn(input string name, input logic [15:0] d, input logic [7:0] a,
                         input logic [1:0] m);
    logic [7:0] o0, o1, v0, v1;
    int e0, e1, mx, cnt, lat1, lat3;
    model(d[7:0], a[3:0], m, o0, v0, e0);
    model(d[15:8], a[7:4], m, o1, v1, e1);
    mx = (e0 > e1) ? e0 : e1;
    wait_ready();
    in_packed = d; amt_packed = a; mode = m; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++;
    if (rdy1 !== 1'b0 || rdy3 !== 1'b0) begin
      fails++;
      $display("FAIL %s in_ready_after_accept: got %b/%b, required 0/0", name, rdy1, rdy3);
    end
    cnt = 0; lat1 = -1; lat3 = -1;
    while ((lat1 < 0 || lat3 < 0) && cnt < 64) begin
      @(negedge clk);
      cnt++;
      if (lat1 < 0 && ov1) lat1 = cnt;
      if (lat3 < 0 && ov3) lat3 = cnt;
    end
    tests++;
    if (lat1 != exp_lat(mx, 1) || lat3 != exp_lat(mx, 3)) begin
      fails++;
      $display("FAIL %s latency: got %0d/%0d, required %0d/%0d", name, lat1, lat3,
               exp_lat(mx, 1), exp_lat(mx, 3));
    end
    tests++;
    if (out1 !== {o1, o0} || ovf1 !== {v1, v0}) begin
      fails++;
      $display("FAIL %s step1_result: got out=%h ovf=%h, required out=%h ovf=%h",
               name, out1, ovf1, {o1, o0}, {v1, v0});
    end
    tests++;
    if (out3 !== {o1, o0} || ovf3 !== {v1, v0}) begin
      fails++;
      $display("FAIL %s step3_result: got out=%h ovf=%h, required out=%h ovf=%h",
               name, out3, ovf3, {o1, o0}, {v1, v0});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (ov1 !== 1'b0 || ov3 !== 1'b0) begin
      fails++;
      $display("FAIL %s drain: out_valid got %b/%b, required 0/0", name, ov1, ov3);
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if (ov1 !== 1'b0 || busy1 !== 1'b0 || out1 !== 16'h0 || ovf1 !== 16'h0 ||
        ov3 !== 1'b0 || busy3 !== 1'b0 || out3 !== 16'h0 || ovf3 !== 16'h0) begin
      fails++;
      $display("FAIL reset_state: got ov=%b busy=%b out=%h ovf=%h, required 0 0 0000 0000",
               ov1, busy1, out1, ovf1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (rdy1 !== 1'b1 || rdy3 !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b/%b, required 1/1", rdy1, rdy3);
    end
  endtask

  task automatic test_directed();
    run_txn("lsl", 16'h0196, 8'h73, 2'd0);
    tests++;
    if (out1 !== 16'h80B0 || ovf1 !== 16'h0004) begin
      fails++;
      $display("FAIL lsl_literal: got out=%h ovf=%h, required 80b0 0004", out1, ovf1);
    end
    run_txn("asr", 16'h1296, 8'h52, 2'd2);
    run_txn("lsr", 16'h9633, 8'h41, 2'd1);
    run_txn("sat_lsl", 16'h3CA5, 8'hF9, 2'd0);
    run_txn("sat_asr", 16'h7F80, 8'h88, 2'd2);
    run_txn("amt_zero", 16'hC396, 8'h00, 2'd1);
    run_txn("ror4", 16'h9696, 8'h44, 2'd3);
    run_txn("ror7", 16'h0196, 8'h77, 2'd3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      run_txn("random", 16'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] o0, o1, v0, v1;
    int e0, e1, n;
    model(8'h96, 4'd3, 2'd0, o0, v0, e0);
    model(8'h5A, 4'd5, 2'd0, o1, v1, e1);
    wait_ready();
    in_packed = 16'h5A96; amt_packed = 8'h53; mode = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!(ov1 && ov3) && n < 40) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (ov1 !== 1'b1 || rdy1 !== 1'b0 || out1 !== {o1, o0} || ovf1 !== {v1, v0}) begin
        fails++;
        $display("FAIL backpressure_hold: cycle %0d got ov=%b rdy=%b out=%h ovf=%h, required 1 0 %h %h",
                 c, ov1, rdy1, out1, ovf1, {o1, o0}, {v1, v0});
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++;
    if (ov1 !== 1'b0 || rdy1 !== 1'b1 || ov3 !== 1'b0 || rdy3 !== 1'b1) begin
      fails++;
      $display("FAIL backpressure_release: got ov=%b rdy=%b, required 0 1", ov1, rdy1);
    end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    in_packed = 16'hA596; amt_packed = 8'h77; mode = 2'd0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy: got %b, required 1", busy1);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (ov1 !== 1'b0 || busy1 !== 1'b0 || out1 !== 16'h0 || ovf1 !== 16'h0 ||
        ov3 !== 1'b0 || busy3 !== 1'b0 || out3 !== 16'h0 || ovf3 !== 16'h0) begin
      fails++;
      $display("FAIL reset_mid_clear: got ov=%b busy=%b out=%h ovf=%h, required 0 0 0000 0000",
               ov1, busy1, out1, ovf1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn("after_reset", 16'h3C96, 8'h26, 2'd1);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
